// File: rtl/vga_timing_out.sv
// VGA sink: pixel divider, h/v raster counters, sync/blank decode and registered pins.
// Latency: pins lag pixel_x/pixel_y by 1 clk; no backpressure (free-running raster, source must keep up).
module vga_timing_out #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  red,
    input  logic [3:0]  green,
    input  logic [3:0]  blue,
    output logic [10:0] pixel_x,
    output logic [9:0]  pixel_y,
    output logic        pix_tick,
    output logic        frame_start,
    output logic [3:0]  vga_red,
    output logic [3:0]  vga_green,
    output logic [3:0]  vga_blue,
    output logic        hsync,
    output logic        vsync,
    output logic        active
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // A 1-bit divider register is kept even for CLK_DIV == 1; it simply never leaves 0.
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0]      H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0]      H_VIS_END  = 11'(H_ACTIVE);
    localparam logic [10:0]      H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0]      H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]       V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]       V_VIS_END  = 10'(V_ACTIVE);
    localparam logic [9:0]       V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]       V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] r_div_cnt;
    logic [10:0]      r_h_cnt;
    logic [9:0]       r_v_cnt;
    logic [3:0]       r_red;
    logic [3:0]       r_green;
    logic [3:0]       r_blue;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_active;

    logic w_tick;
    logic w_h_wrap;
    logic w_v_wrap;
    logic w_vis;
    logic w_hs;
    logic w_vs;

    assign w_tick   = (r_div_cnt == DIV_LAST);
    assign w_h_wrap = (r_h_cnt == H_LAST);
    assign w_v_wrap = (r_v_cnt == V_LAST);

    assign w_vis = (r_h_cnt < H_VIS_END) && (r_v_cnt < V_VIS_END);
    assign w_hs  = (r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END);
    assign w_vs  = (r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            if (w_tick) begin
                if (w_h_wrap) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
                end else begin
                    r_h_cnt <= r_h_cnt + 1'b1;
                end
            end
        end
    end

    // Pins update every clk so colour changes inside a pixel period pass straight through.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_red    <= 4'h0;
            r_green  <= 4'h0;
            r_blue   <= 4'h0;
            r_hsync  <= ~SYNC_POL;
            r_vsync  <= ~SYNC_POL;
            r_active <= 1'b0;
        end else begin
            r_red    <= w_vis ? red   : 4'h0;
            r_green  <= w_vis ? green : 4'h0;
            r_blue   <= w_vis ? blue  : 4'h0;
            r_hsync  <= w_hs ? SYNC_POL : ~SYNC_POL;
            r_vsync  <= w_vs ? SYNC_POL : ~SYNC_POL;
            r_active <= w_vis;
        end
    end

    assign pixel_x     = r_h_cnt;
    assign pixel_y     = r_v_cnt;
    assign pix_tick    = w_tick;
    assign frame_start = w_tick && w_h_wrap && w_v_wrap;
    assign vga_red     = r_red;
    assign vga_green   = r_green;
    assign vga_blue    = r_blue;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign active      = r_active;

endmodule
